// File: rtl/bm_free_list.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : bm_free_list
// Purpose  : Buffer free list (circular FIFO in 1r1w RAM) with 2-entry alloc
//            prefetch. Optional BM_DOUBLE_FREE_CHECK_EN adds a double-free bitmap.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------

`ifndef BUF_PTR_NBITS
`define BUF_PTR_NBITS 4
`endif
`ifndef PORT_ID_NBITS
`define PORT_ID_NBITS 4
`endif
`ifndef RESET_SIG
`define RESET_SIG rst_n
`endif

module bm_free_list #(
  parameter int NUM_BUFS        = 2**`BUF_PTR_NBITS,
  parameter int FREE_LOW_THRESH = 16
) (
  input  logic                        clk,
  input  logic                        `RESET_SIG,
  input  logic                        rel_buf_valid,
  input  logic [`PORT_ID_NBITS-1:0]   rel_buf_port_id,
  input  logic [`BUF_PTR_NBITS-1:0]   rel_buf_ptr,
  input  logic                        alloc_req,
  output logic                        alloc_ready,
  output logic [`BUF_PTR_NBITS-1:0]   alloc_buf_ptr,
  output logic                        init_read_count_valid,
  output logic [`BUF_PTR_NBITS-1:0]   init_read_count_ptr,
  output logic [`BUF_PTR_NBITS:0]     free_count,
  output logic                        free_low,
  output logic                        init_done,
  output logic                        err_rel,
  output logic [`PORT_ID_NBITS-1:0]   err_port_id
);

  localparam int PW = `BUF_PTR_NBITS;
  localparam logic [PW-1:0] c_LAST_PTR   = PW'(NUM_BUFS - 1);
  localparam logic [PW:0]   c_NUM_BUFS   = (PW+1)'(NUM_BUFS);
  localparam logic [PW:0]   c_LOW_THRESH = (PW+1)'(FREE_LOW_THRESH);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                     r_state, w_state_nxt;
  logic                       r_init_active;
  logic [PW-1:0]              r_i;
  logic [PW-1:0]              r_mem [NUM_BUFS];
  logic [PW-1:0]              r_rd_data;
  logic                       r_rd_pend;
  logic [PW-1:0]              r_head, r_tail;
  logic [PW:0]                r_ram_cnt, r_free_count;
  logic [1:0]                 r_pf_cnt, w_pf_cnt_nxt;
  logic [PW-1:0]              r_pf_d0, r_pf_d1, w_pf_d0_nxt, w_pf_d1_nxt;
  logic                       r_alloc_ready, r_init_done, r_err_rel, r_free_low;
  logic [`PORT_ID_NBITS-1:0]  r_err_port_id;

  logic          w_run, w_pop, w_full_drop, w_map_ok, w_rel_ok, w_rel_err;
  logic          w_ram_avail, w_rd_en, w_wr_en;
  logic [2:0]    w_occ_after_pop;
  logic [PW-1:0] w_wr_addr, w_wr_data;

  function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
    return (p == c_LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign w_run       = (r_state == ST_RUN);
  assign w_pop       = alloc_req && r_alloc_ready;
  assign w_full_drop = (r_free_count == c_NUM_BUFS) && !w_pop;
  assign w_rel_ok    = rel_buf_valid && w_run && !w_full_drop && w_map_ok;
  assign w_rel_err   = rel_buf_valid && !w_rel_ok;

  // A release into an empty RAM is read the same cycle via the write bypass.
  assign w_ram_avail     = (r_ram_cnt != '0) || w_rel_ok;
  assign w_occ_after_pop = {1'b0, r_pf_cnt} + {2'b0, r_rd_pend} - {2'b0, w_pop};
  assign w_rd_en         = w_run && w_ram_avail && (w_occ_after_pop < 3'd2);

  assign w_wr_en   = r_init_active || w_rel_ok;
  assign w_wr_addr = r_init_active ? r_i : r_tail;
  assign w_wr_data = r_init_active ? r_i : rel_buf_ptr;

`ifdef BM_DOUBLE_FREE_CHECK_EN
  logic [NUM_BUFS-1:0] r_alloc_map;

  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_alloc_map <= '0;
    end else begin
      if (w_pop)    r_alloc_map[r_pf_d0]     <= 1'b1;
      if (w_rel_ok) r_alloc_map[rel_buf_ptr] <= 1'b0;
    end
  end

  assign w_map_ok = r_alloc_map[rel_buf_ptr];
`else
  assign w_map_ok = 1'b1;
`endif

  // Free-list storage; deliberately not reset, INIT rebuilds it.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= w_wr_data;
    if (w_rd_en) r_rd_data <= (w_wr_en && (w_wr_addr == r_head)) ? w_wr_data : r_mem[r_head];
  end

  always_ff @(posedge clk or negedge `RESET_SIG) begin
    if (!`RESET_SIG) r_state <= ST_INIT;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pf_cnt_nxt = r_pf_cnt;
    w_pf_d0_nxt  = r_pf_d0;
    w_pf_d1_nxt  = r_pf_d1;
    if (r_state == ST_INIT && r_init_active && r_i == c_LAST_PTR) w_state_nxt = ST_RUN;
    if (w_pop) begin
      w_pf_d0_nxt  = r_pf_d1;
      w_pf_cnt_nxt = r_pf_cnt - 2'd1;
    end
    if (r_rd_pend) begin
      if (w_pf_cnt_nxt == 2'd0) w_pf_d0_nxt = r_rd_data;
      else                      w_pf_d1_nxt = r_rd_data;
      w_pf_cnt_nxt = w_pf_cnt_nxt + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge `RESET_SIG) begin
    if (!`RESET_SIG) begin
      r_init_active <= 1'b0;
      r_i           <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_ram_cnt     <= '0;
      r_free_count  <= '0;
      r_rd_pend     <= 1'b0;
      r_pf_cnt      <= '0;
      r_pf_d0       <= '0;
      r_pf_d1       <= '0;
      r_alloc_ready <= 1'b0;
      r_init_done   <= 1'b0;
      r_err_rel     <= 1'b0;
      r_err_port_id <= '0;
      r_free_low    <= 1'b0;
    end else begin
      r_err_rel  <= w_rel_err;
      r_free_low <= (r_free_count < c_LOW_THRESH);
      if (w_rel_err) r_err_port_id <= rel_buf_port_id;
      if (r_state == ST_INIT) begin
        if (!r_init_active) begin
          r_init_active <= 1'b1;
        end else if (r_i == c_LAST_PTR) begin
          r_init_active <= 1'b0;
          r_i           <= '0;
          r_head        <= '0;
          r_tail        <= '0;
          r_ram_cnt     <= c_NUM_BUFS;
          r_free_count  <= c_NUM_BUFS;
          r_init_done   <= 1'b1;
        end else begin
          r_i <= r_i + PW'(1);
        end
      end else begin
        if (w_rel_ok) r_tail <= f_ptr_inc(r_tail);
        if (w_rd_en)  r_head <= f_ptr_inc(r_head);
        r_ram_cnt     <= r_ram_cnt + {{PW{1'b0}}, w_rel_ok} - {{PW{1'b0}}, w_rd_en};
        r_free_count  <= r_free_count + {{PW{1'b0}}, w_rel_ok} - {{PW{1'b0}}, w_pop};
        r_rd_pend     <= w_rd_en;
        r_pf_cnt      <= w_pf_cnt_nxt;
        r_pf_d0       <= w_pf_d0_nxt;
        r_pf_d1       <= w_pf_d1_nxt;
        r_alloc_ready <= (w_pf_cnt_nxt != 2'd0);
      end
    end
  end

  assign alloc_ready           = r_alloc_ready;
  assign alloc_buf_ptr         = r_pf_d0;
  assign init_read_count_valid = r_init_active;
  assign init_read_count_ptr   = r_i;
  assign free_count            = r_free_count;
  assign free_low              = r_free_low;
  assign init_done             = r_init_done;
  assign err_rel               = r_err_rel;
  assign err_port_id           = r_err_port_id;

endmodule

`default_nettype wire

// File: tb/tb_bm_free_list.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_bm_free_list
// Purpose  : Directed self-checking bench for bm_free_list (NUM_BUFS=16, thresh 4).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bm_free_list;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rel_buf_valid;
  logic [3:0] rel_buf_port_id;
  logic [3:0] rel_buf_ptr;
  logic       alloc_req;
  logic       alloc_ready;
  logic [3:0] alloc_buf_ptr;
  logic       init_read_count_valid;
  logic [3:0] init_read_count_ptr;
  logic [4:0] free_count;
  logic       free_low;
  logic       init_done;
  logic       err_rel;
  logic [3:0] err_port_id;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bm_free_list #(.NUM_BUFS(16), .FREE_LOW_THRESH(4)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .rel_buf_valid         (rel_buf_valid),
    .rel_buf_port_id       (rel_buf_port_id),
    .rel_buf_ptr           (rel_buf_ptr),
    .alloc_req             (alloc_req),
    .alloc_ready           (alloc_ready),
    .alloc_buf_ptr         (alloc_buf_ptr),
    .init_read_count_valid (init_read_count_valid),
    .init_read_count_ptr   (init_read_count_ptr),
    .free_count            (free_count),
    .free_low              (free_low),
    .init_done             (init_done),
    .err_rel               (err_rel),
    .err_port_id           (err_port_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rel_buf_valid = 1'b0; rel_buf_port_id = '0; rel_buf_ptr = '0; alloc_req = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({alloc_ready, init_read_count_valid, init_done, err_rel, free_low} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {alloc_ready, init_read_count_valid, init_done, err_rel, free_low});
    end
    n_checks++;
    if (free_count !== 5'd0) begin
      n_errors++; $display("FAIL reset_free_count: got %0d expected 0", free_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    int cnt = 0;
    while (init_read_count_valid !== 1'b1 && cnt < 5) begin tick(); cnt++; end
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (init_read_count_valid !== 1'b1 || init_read_count_ptr !== 4'(k)) begin
        n_errors++;
        $display("FAIL init_step %0d: got valid=%b ptr=%0d expected valid=1 ptr=%0d",
                 k, init_read_count_valid, init_read_count_ptr, k);
      end
      if (k == 5) begin
        n_checks++;
        if (err_rel !== 1'b1 || err_port_id !== 4'd2) begin
          n_errors++;
          $display("FAIL init_release_err: got err=%b port=%0d expected err=1 port=2", err_rel, err_port_id);
        end
      end
      rel_buf_valid = (k == 4); rel_buf_port_id = 4'd2; rel_buf_ptr = 4'd1;
      tick();
    end
    rel_buf_valid = 1'b0;
    n_checks++;
    if (init_done !== 1'b1 || free_count !== 5'd16 || init_read_count_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL init_end: got done=%b count=%0d irc=%b expected done=1 count=16 irc=0",
               init_done, free_count, init_read_count_valid);
    end
    cnt = 0;
    while (alloc_ready !== 1'b1 && cnt < 3) begin tick(); cnt++; end
    n_checks++;
    if (alloc_ready !== 1'b1 || alloc_buf_ptr !== 4'd0) begin
      n_errors++;
      $display("FAIL init_first_ready: got ready=%b ptr=%0d expected ready=1 ptr=0", alloc_ready, alloc_buf_ptr);
    end
    n_checks++;
    if (free_low !== 1'b0) begin
      n_errors++; $display("FAIL init_free_low: got %b expected 0", free_low);
    end
  endtask

  task automatic test_overflow();
    rel_buf_valid = 1'b1; rel_buf_port_id = 4'd3; rel_buf_ptr = 4'd9;
    tick();
    rel_buf_valid = 1'b0; rel_buf_port_id = 4'd0;
    n_checks++;
    if (err_rel !== 1'b1 || err_port_id !== 4'd3 || free_count !== 5'd16) begin
      n_errors++;
      $display("FAIL overflow_err: got err=%b port=%0d count=%0d expected err=1 port=3 count=16",
               err_rel, err_port_id, free_count);
    end
    tick();
    n_checks++;
    if (err_rel !== 1'b0 || err_port_id !== 4'd3 || free_count !== 5'd16) begin
      n_errors++;
      $display("FAIL overflow_pulse: got err=%b port=%0d count=%0d expected err=0 port=3 count=16",
               err_rel, err_port_id, free_count);
    end
  endtask

  task automatic test_drain();
    alloc_req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (alloc_ready !== 1'b1 || alloc_buf_ptr !== 4'(k)) begin
        n_errors++;
        $display("FAIL drain_ptr %0d: got ready=%b ptr=%0d expected ready=1 ptr=%0d", k, alloc_ready, alloc_buf_ptr, k);
      end
      if (k == 13 || k == 14) begin
        n_checks++;
        if (free_count !== 5'(16 - k) || free_low !== (k == 14)) begin
          n_errors++;
          $display("FAIL drain_free_low %0d: got count=%0d low=%b expected count=%0d low=%b",
                   k, free_count, free_low, 16 - k, (k == 14));
        end
      end
      tick();
    end
    alloc_req = 1'b0;
    n_checks++;
    if (free_count !== 5'd0 || alloc_ready !== 1'b0 || free_low !== 1'b1) begin
      n_errors++;
      $display("FAIL drain_end: got count=%0d ready=%b low=%b expected count=0 ready=0 low=1",
               free_count, alloc_ready, free_low);
    end
  endtask

  task automatic test_empty_release();
    int cnt = 1;
    rel_buf_valid = 1'b1; rel_buf_ptr = 4'd7;
    tick();
    rel_buf_valid = 1'b0;
    while (alloc_ready !== 1'b1 && cnt < 3) begin tick(); cnt++; end
    n_checks++;
    if (alloc_ready !== 1'b1 || alloc_buf_ptr !== 4'd7 || free_count !== 5'd1) begin
      n_errors++;
      $display("FAIL empty_release: got ready=%b ptr=%0d count=%0d expected ready=1 ptr=7 count=1",
               alloc_ready, alloc_buf_ptr, free_count);
    end
    alloc_req = 1'b1;
    tick();
    alloc_req = 1'b0;
    n_checks++;
    if (free_count !== 5'd0 || err_rel !== 1'b0) begin
      n_errors++; $display("FAIL empty_repop: got count=%0d err=%b expected count=0 err=0", free_count, err_rel);
    end
  endtask

  task automatic test_back_to_back();
    int exp_ptr [8] = '{9, 10, 11, 12, 13, 14, 15, 5};
    for (int k = 0; k < 8; k++) begin
      rel_buf_valid = 1'b1; rel_buf_ptr = 4'(8 + k);
      tick();
    end
    rel_buf_valid = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (free_count !== 5'd8 || alloc_ready !== 1'b1 || alloc_buf_ptr !== 4'd8) begin
      n_errors++;
      $display("FAIL refill: got count=%0d ready=%b ptr=%0d expected count=8 ready=1 ptr=8",
               free_count, alloc_ready, alloc_buf_ptr);
    end
    alloc_req = 1'b1; rel_buf_valid = 1'b1; rel_buf_ptr = 4'd5;
    tick();
    alloc_req = 1'b0; rel_buf_valid = 1'b0;
    n_checks++;
    if (free_count !== 5'd8 || err_rel !== 1'b0) begin
      n_errors++;
      $display("FAIL pop_and_release: got count=%0d err=%b expected count=8 err=0", free_count, err_rel);
    end
    repeat (2) tick();
    alloc_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (alloc_ready !== 1'b1 || alloc_buf_ptr !== 4'(exp_ptr[k])) begin
        n_errors++;
        $display("FAIL order %0d: got ready=%b ptr=%0d expected ready=1 ptr=%0d",
                 k, alloc_ready, alloc_buf_ptr, exp_ptr[k]);
      end
      tick();
    end
    alloc_req = 1'b0;
    n_checks++;
    if (free_count !== 5'd0 || alloc_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL order_end: got count=%0d ready=%b expected count=0 ready=0", free_count, alloc_ready);
    end
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    for (int k = 0; k < 6; k++) begin
      rel_buf_valid = 1'b1; rel_buf_ptr = 4'(k);
      tick();
    end
    rel_buf_valid = 1'b0;
    repeat (3) tick();
    alloc_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (alloc_ready !== 1'b1 || alloc_buf_ptr !== 4'(k)) begin
        n_errors++;
        $display("FAIL pre_reset_alloc %0d: got ready=%b ptr=%0d expected ready=1 ptr=%0d",
                 k, alloc_ready, alloc_buf_ptr, k);
      end
      tick();
    end
    alloc_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({alloc_ready, init_done, err_rel, init_read_count_valid} !== 4'b0 ||
        free_count !== 5'd0 || err_port_id !== 4'd0) begin
      n_errors++;
      $display("FAIL async_reset: got ready=%b done=%b err=%b irc=%b count=%0d port=%0d expected all 0",
               alloc_ready, init_done, err_rel, init_read_count_valid, free_count, err_port_id);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    while (init_done !== 1'b1 && cnt < 40) begin tick(); cnt++; end
    n_checks++;
    if (init_done !== 1'b1 || free_count !== 5'd16) begin
      n_errors++;
      $display("FAIL reinit: got done=%b count=%0d expected done=1 count=16", init_done, free_count);
    end
    cnt = 0;
    while (alloc_ready !== 1'b1 && cnt < 3) begin tick(); cnt++; end
    n_checks++;
    if (alloc_ready !== 1'b1 || alloc_buf_ptr !== 4'd0) begin
      n_errors++;
      $display("FAIL reinit_first: got ready=%b ptr=%0d expected ready=1 ptr=0", alloc_ready, alloc_buf_ptr);
    end
  endtask

`ifdef BM_DOUBLE_FREE_CHECK_EN
  task automatic test_double_free();
    repeat (2) tick();
    alloc_req = 1'b1;
    repeat (2) tick();
    alloc_req = 1'b0;
    rel_buf_valid = 1'b1; rel_buf_ptr = 4'd0; rel_buf_port_id = 4'd6;
    tick();
    n_checks++;
    if (err_rel !== 1'b0) begin
      n_errors++; $display("FAIL first_free: got err=%b expected 0", err_rel);
    end
    tick();
    rel_buf_valid = 1'b0;
    n_checks++;
    if (err_rel !== 1'b1 || err_port_id !== 4'd6) begin
      n_errors++;
      $display("FAIL double_free: got err=%b port=%0d expected err=1 port=6", err_rel, err_port_id);
    end
    tick();
    n_checks++;
    if (free_count !== 5'd15) begin
      n_errors++; $display("FAIL double_free_count: got %0d expected 15", free_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_init();
    test_overflow();
    test_drain();
    test_empty_release();
    test_back_to_back();
    test_reset_mid();
`ifdef BM_DOUBLE_FREE_CHECK_EN
    test_double_free();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
